missile_unit: RTL and testbench

//  Player projectile engine; sits directly upstream of the boss block and produces its is_hit input.

---
 rtl/missile_unit.sv | 146 ++++++++++++++
 tb/tb_missile_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/missile_unit.sv
// Player projectile engine: spawns, moves and retires missiles once per frame,
// drives the boss hit strobe and the per-pixel missile flag.
module missile_unit #(
  parameter int unsigned NUM_MISSILES  = 4,
  parameter logic [9:0]  MISSILE_STEP  = 10'd6,
  parameter logic [9:0]  Y_TOP         = 10'd8,
  parameter logic [9:0]  SPAWN_OFS     = 10'd20,
  parameter logic [9:0]  HIT_HALF_W    = 10'd48,
  parameter logic [9:0]  HIT_HALF_H    = 10'd40,
  parameter logic [3:0]  HIT_HOLD      = 4'd8,
  parameter logic [3:0]  FIRE_COOLDOWN = 4'd10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic       is_boss_dead,
  input  logic [9:0] ship_x_pos,
  input  logic [9:0] ship_y_pos,
  input  logic [9:0] boss_x_pos,
  input  logic [9:0] boss_y_pos,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_missile,
  output logic       is_hit,
  output logic [2:0] missile_count
);

  // 11-bit thresholds so parameter sums never wrap
  localparam logic [10:0] RetireY = {1'b0, Y_TOP} + {1'b0, MISSILE_STEP};
  localparam logic [10:0] ClampY  = {1'b0, Y_TOP} + {1'b0, SPAWN_OFS};

  logic                         r_frame_d, r_frame_tick, r_fire_d, r_fire_pend;
  logic [NUM_MISSILES-1:0]      r_active;
  logic [NUM_MISSILES-1:0][9:0] r_x, r_y;
  logic [3:0]                   r_hold, r_cool;

  logic [NUM_MISSILES-1:0]      w_active_d;
  logic [NUM_MISSILES-1:0][9:0] w_x_d, w_y_d;
  logic [3:0]                   w_hold_d, w_cool_d;
  logic                         w_hit_d, w_fire_pend_d, w_any_hit, w_spawned;
  logic [9:0]                   w_spawn_y;
  logic [2:0]                   w_count_d;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // A fire edge coinciding with the frame tick is kept for the following frame
  assign w_fire_pend_d = (fire & ~r_fire_d) | (r_fire_pend & ~r_frame_tick);
  assign w_spawn_y     = ({1'b0, ship_y_pos} < ClampY) ? Y_TOP : ship_y_pos - SPAWN_OFS;

  always_comb begin
    w_active_d = r_active;
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_hold_d   = r_hold;
    w_cool_d   = r_cool;
    w_hit_d    = is_hit;
    w_any_hit  = 1'b0;
    w_spawned  = 1'b0;
    if (r_frame_tick) begin
      for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
        if (r_active[i]) begin
          if ({1'b0, r_y[i]} < RetireY) w_active_d[i] = 1'b0;
          else                          w_y_d[i]      = r_y[i] - MISSILE_STEP;
        end
      end
      if (!is_boss_dead) begin
        for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
          if (w_active_d[i] && abs_diff(r_x[i], boss_x_pos) <= HIT_HALF_W &&
              abs_diff(w_y_d[i], boss_y_pos) <= HIT_HALF_H) begin
            w_active_d[i] = 1'b0;
            w_any_hit     = 1'b1;
          end
        end
      end
      // A hit during a running hold is absorbed; the hold keeps counting down
      if (w_any_hit && r_hold == 4'd0) begin
        w_hit_d  = 1'b1;
        w_hold_d = HIT_HOLD;
      end else if (r_hold != 4'd0) begin
        w_hold_d = r_hold - 4'd1;
        w_hit_d  = (r_hold != 4'd1);
      end
      if (r_fire_pend && r_cool == 4'd0 && !is_boss_dead) begin
        for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
          if (!r_active[i] && !w_spawned) begin
            w_spawned     = 1'b1;
            w_active_d[i] = 1'b1;
            w_x_d[i]      = ship_x_pos;
            w_y_d[i]      = w_spawn_y;
          end
        end
      end
      if (w_spawned)              w_cool_d = FIRE_COOLDOWN;
      else if (r_cool != 4'd0)    w_cool_d = r_cool - 4'd1;
    end
  end

  always_comb begin
    w_count_d = 3'd0;
    for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
      w_count_d = w_count_d + 3'(w_active_d[i]);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_frame_d     <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_fire_d      <= 1'b0;
      r_fire_pend   <= 1'b0;
      r_active      <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_hold        <= 4'd0;
      r_cool        <= 4'd0;
      is_hit        <= 1'b0;
      missile_count <= 3'd0;
    end else begin
      r_frame_d     <= frame_clk;
      r_frame_tick  <= frame_clk & ~r_frame_d;
      r_fire_d      <= fire;
      r_fire_pend   <= w_fire_pend_d;
      r_active      <= w_active_d;
      r_x           <= w_x_d;
      r_y           <= w_y_d;
      r_hold        <= w_hold_d;
      r_cool        <= w_cool_d;
      is_hit        <= w_hit_d;
      missile_count <= w_count_d;
    end
  end

  // 3x9 pixel sprite centred on each active missile
  always_comb begin
    is_missile = 1'b0;
    for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
      if (r_active[i] && abs_diff(DrawX, r_x[i]) <= 10'd1 && abs_diff(DrawY, r_y[i]) <= 10'd4) begin
        is_missile = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_missile_unit.sv
// Self-checking bench for missile_unit: directed frame sequences plus randomized
// frames checked against a frame-level behavioural model.
module tb_missile_unit;

  localparam int NM = 4;

  logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, fire = 1'b0, is_boss_dead = 1'b0;
  logic [9:0] ship_x_pos, ship_y_pos, boss_x_pos, boss_y_pos, DrawX, DrawY;
  logic       is_missile, is_hit, is_missile2, is_hit2;
  logic [2:0] missile_count, missile_count2;

  int checks = 0;
  int errors = 0;

  // Frame-level reference state
  bit m_act[NM];
  int m_x[NM];
  int m_y[NM];
  int m_hold, m_cool;

  typedef struct {
    int dx;
    int dy;
    int exp;
  } pix_vec_t;
  pix_vec_t vec[10];

  missile_unit u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
    .is_boss_dead(is_boss_dead), .ship_x_pos(ship_x_pos), .ship_y_pos(ship_y_pos),
    .boss_x_pos(boss_x_pos), .boss_y_pos(boss_y_pos), .DrawX(DrawX), .DrawY(DrawY),
    .is_missile(is_missile), .is_hit(is_hit), .missile_count(missile_count)
  );

  missile_unit #(.FIRE_COOLDOWN(4'd0)) u_dut_nocool (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
    .is_boss_dead(is_boss_dead), .ship_x_pos(ship_x_pos), .ship_y_pos(ship_y_pos),
    .boss_x_pos(boss_x_pos), .boss_y_pos(boss_y_pos), .DrawX(DrawX), .DrawY(DrawY),
    .is_missile(is_missile2), .is_hit(is_hit2), .missile_count(missile_count2)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int model_pix(input int px, input int py);
    for (int i = 0; i < NM; i++)
      if (m_act[i] && absd(px, m_x[i]) <= 1 && absd(py, m_y[i]) <= 4) return 1;
    return 0;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NM; i++) c += int'(m_act[i]);
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NM; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_hold = 0;
    m_cool = 0;
  endtask

  // One frame of the game rules: move, hit, hold, spawn, cooldown
  task automatic model_tick(input bit pend);
    bit was_act[NM];
    bit any_hit = 1'b0;
    bit spawned = 1'b0;
    was_act = m_act;
    for (int i = 0; i < NM; i++)
      if (m_act[i]) begin
        if (m_y[i] < 8 + 6) m_act[i] = 1'b0;
        else                m_y[i] -= 6;
      end
    if (!is_boss_dead)
      for (int i = 0; i < NM; i++)
        if (m_act[i] && absd(m_x[i], int'(boss_x_pos)) <= 48 &&
            absd(m_y[i], int'(boss_y_pos)) <= 40) begin
          m_act[i] = 1'b0;
          any_hit  = 1'b1;
        end
    if (any_hit && m_hold == 0) m_hold = 8;
    else if (m_hold > 0)        m_hold--;
    if (pend && m_cool == 0 && !is_boss_dead)
      for (int i = 0; i < NM; i++)
        if (!was_act[i] && !spawned) begin
          spawned  = 1'b1;
          m_act[i] = 1'b1;
          m_x[i]   = int'(ship_x_pos);
          m_y[i]   = (int'(ship_y_pos) - 20 < 8) ? 8 : int'(ship_y_pos) - 20;
        end
    if (spawned)         m_cool = 10;
    else if (m_cool > 0) m_cool--;
  endtask

  task automatic check_frame(input string tag);
    int k, px, py;
    chk({tag, "_hit"}, int'(is_hit), int'(m_hold != 0));
    chk({tag, "_count"}, int'(missile_count), model_count());
    k = int'($urandom_range(0, NM - 1));
    if (m_act[k]) begin
      px = m_x[k] + int'($urandom_range(0, 4)) - 2;
      py = m_y[k] + int'($urandom_range(0, 10)) - 5;
    end else begin
      px = int'($urandom_range(0, 639));
      py = int'($urandom_range(0, 479));
    end
    DrawX = 10'(px);
    DrawY = 10'(py);
    #1;
    chk({tag, "_pix"}, int'(is_missile), model_pix(px, py));
  endtask

  // Fire edge (optional) well before the frame tick, tick two clocks after frame_clk rises
  task automatic frame(input bit do_fire, input string tag);
    if (do_fire) begin
      fire = 1'b1; step();
      fire = 1'b0; step();
    end else begin
      step(); step();
    end
    frame_clk = 1'b1;
    step(); step();
    model_tick(do_fire);
    check_frame(tag);
    frame_clk = 1'b0;
    step(); step();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; frame_clk = 1'b0; fire = 1'b0; is_boss_dead = 1'b0;
    step(); step();
    Reset_n = 1'b1;
    step();
    model_reset();
  endtask

  task automatic probe(input string name, input int px, input int py, input int exp);
    DrawX = 10'(px);
    DrawY = 10'(py);
    #1;
    chk(name, int'(is_missile), exp);
  endtask

  initial begin
    vec[0] = '{320, 380, 1};  vec[1] = '{319, 376, 1};  vec[2] = '{321, 384, 1};
    vec[3] = '{318, 380, 0};  vec[4] = '{322, 380, 0};  vec[5] = '{320, 375, 0};
    vec[6] = '{320, 385, 0};  vec[7] = '{321, 376, 1};  vec[8] = '{322, 385, 0};
    vec[9] = '{60, 160, 0};

    ship_x_pos = 10'd320; ship_y_pos = 10'd400;
    boss_x_pos = 10'd60;  boss_y_pos = 10'd160;
    DrawX = '0; DrawY = '0;
    do_reset();
    chk("reset_hit", int'(is_hit), 0);
    chk("reset_count", int'(missile_count), 0);
    chk("reset_pix", int'(is_missile), 0);

    // Flight: spawn at y=380, step 6 per frame, retire on the tick after y=8
    frame(1'b1, "t2");
    for (int v = 0; v < 10; v++) probe($sformatf("pix_table%0d", v), vec[v].dx, vec[v].dy, vec[v].exp);
    for (int k = 1; k <= 64; k++) begin
      frame(1'b0, "t2");
      chk($sformatf("t2_count_k%0d", k), int'(missile_count), (k <= 62) ? 1 : 0);
      if (k <= 62) probe($sformatf("t2_pos_k%0d", k), 320, 380 - 6 * k, 1);
    end

    // Single hit: first y<=200 is tick 30, hold covers ticks 30..37
    do_reset();
    boss_x_pos = 10'd320;
    frame(1'b1, "t3");
    for (int k = 1; k <= 40; k++) begin
      frame(1'b0, "t3");
      chk($sformatf("t3_hit_k%0d", k), int'(is_hit), (k >= 30 && k <= 37) ? 1 : 0);
    end

    // Overlapping hit at tick 33 is absorbed into the running hold
    do_reset();
    boss_x_pos = 10'd320;
    for (int k = 0; k <= 45; k++) begin
      if (k == 11) ship_y_pos = 10'd352;
      frame(k == 0 || k == 11, "t4");
      chk($sformatf("t4_hit_k%0d", k), int'(is_hit), (k >= 30 && k <= 37) ? 1 : 0);
      if (k == 11 || k == 29) chk($sformatf("t4_count_k%0d", k), int'(missile_count), 2);
      if (k == 30) chk("t4_count_k30", int'(missile_count), 1);
      if (k == 33) chk("t4_count_k33", int'(missile_count), 0);
    end

    // Slots and cooldown; the second instance has no cooldown and saturates at 4
    do_reset();
    ship_y_pos = 10'd400;
    boss_x_pos = 10'd60;
    for (int k = 0; k <= 44; k++) begin
      frame(1'b1, "t5");
      if (k == 0 || k == 10) chk($sformatf("t5_count_k%0d", k), int'(missile_count), 1);
      if (k == 11) chk("t5_count_k11", int'(missile_count), 2);
      if (k == 22) chk("t5_count_k22", int'(missile_count), 3);
      if (k == 33 || k == 44) chk($sformatf("t5_count_k%0d", k), int'(missile_count), 4);
      if (k <= 5) begin
        chk($sformatf("t5_nocool_count_k%0d", k), int'(missile_count2), (k < 3) ? k + 1 : 4);
        chk($sformatf("t5_nocool_hit_k%0d", k), int'(is_hit2), 0);
      end
      if (k == 3) begin
        DrawX = 10'd320; DrawY = 10'd380; #1;
        chk("t5_nocool_pix", int'(is_missile2), 1);
      end
    end

    // Dead boss: missile flies through the box untouched, no spawns, count drains
    do_reset();
    frame(1'b1, "t6");
    is_boss_dead = 1'b1;
    boss_x_pos = 10'd320;
    for (int k = 1; k <= 66; k++) begin
      frame(1'b1, "t6");
      chk($sformatf("t6_hit_k%0d", k), int'(is_hit), 0);
      chk($sformatf("t6_count_k%0d", k), int'(missile_count), (k < 63) ? 1 : 0);
    end
    is_boss_dead = 1'b0;

    // Asynchronous reset mid-frame with three missiles in flight
    do_reset();
    boss_x_pos = 10'd60;
    for (int k = 0; k <= 22; k++) frame(1'b1, "t1");
    chk("t1_count_before", int'(missile_count), 3);
    probe("t1_pix_before", 320, 380, 1);
    frame_clk = 1'b1;
    step();
    Reset_n = 1'b0;
    #1;
    chk("t1_count_async", int'(missile_count), 0);
    chk("t1_hit_async", int'(is_hit), 0);
    probe("t1_pix_async", 320, 380, 0);
    frame_clk = 1'b0;
    step(); step();
    Reset_n = 1'b1;
    step();
    model_reset();

    // Randomized frames against the model
    for (int f = 0; f < 400; f++) begin
      if (f % 16 == 0) begin
        int sx;
        sx = int'($urandom_range(40, 600));
        ship_x_pos   = 10'(sx);
        ship_y_pos   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(10, 40))
                                                   : 10'($urandom_range(100, 470));
        boss_x_pos   = 10'(sx + int'($urandom_range(0, 140)) - 70);
        boss_y_pos   = 10'($urandom_range(60, 300));
        is_boss_dead = ($urandom_range(0, 3) == 0);
      end
      frame($urandom_range(0, 1) == 1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
